sigma_delta_frame_ctrl: RTL and testbench

- Drives the sigma_delta_update block: streams camera pixels in and reads each pixel's stored background/variance from an internal per-pixel store.
- Presents the pixel, background and variance to sigma_delta_update, then writes the returned background_next/variance_next back to the store.
- Forwards {pixel, background, variance} downstream to the motion-map stage.
- Sits inside frame_manager, between the pixel input stream and the sigma_delta instance.

---
 rtl/sigma_delta_frame_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_sigma_delta_frame_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sigma_delta_frame_ctrl.sv
// sigma_delta_frame_ctrl: frame sequencer and per-pixel background store
// feeding sigma_delta_update and forwarding results to the motion-map stage.
module sigma_delta_frame_ctrl #(
    parameter int NUM_PIXELS = 76800,
    parameter int ADDR_W     = 17,
    parameter int PIX_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             relearn,
    input  logic             pix_valid,
    output logic             pix_ready,
    input  logic             pix_sof,
    input  logic [PIX_W-1:0] pix_data,
    output logic             sd_enable,
    output logic             sd_wr_background,
    output logic [PIX_W-1:0] sd_curr_pixel,
    output logic [PIX_W-1:0] sd_background,
    output logic [PIX_W-1:0] sd_variance,
    input  logic [PIX_W-1:0] sd_background_next,
    input  logic [PIX_W-1:0] sd_variance_next,
    output logic             out_valid,
    output logic [PIX_W-1:0] out_pixel,
    output logic [PIX_W-1:0] out_background,
    output logic [PIX_W-1:0] out_variance,
    output logic             frame_done,
    output logic             sof_err
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              init_pend_q, init_pend_d;
    logic              frame_init_q, frame_init_d;

    logic              accept;
    logic              start;
    logic              proc;
    logic              last;
    logic              init_flag;
    logic [ADDR_W-1:0] addr;

    logic [2*PIX_W-1:0] mem [NUM_PIXELS];
    logic [2*PIX_W-1:0] rd_q;

    logic              s1_valid;
    logic [ADDR_W-1:0] s1_addr;
    logic              s1_last;

    logic              s2_valid;
    logic [ADDR_W-1:0] s2_addr;
    logic [PIX_W-1:0]  s2_pixel;
    logic              s2_last;

    // The block never stalls; it only refuses beats while held in reset.
    assign pix_ready = ~rst;
    assign accept    = pix_valid & pix_ready;

    // Frame sequencing: pick address and init flag for the accepted beat.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        init_pend_d  = init_pend_q | relearn;
        frame_init_d = frame_init_q;
        start        = 1'b0;
        proc         = 1'b0;
        last         = 1'b0;
        sof_err      = 1'b0;
        addr         = cnt_q;
        init_flag    = frame_init_q;
        unique case (state_q)
            IDLE: begin
                if (accept && pix_sof) begin
                    start = 1'b1;
                end
            end
            RUN: begin
                if (accept) begin
                    proc = 1'b1;
                    if (pix_sof && cnt_q != '0) begin
                        start   = 1'b1;
                        sof_err = 1'b1;
                    end
                end
            end
            default: ;
        endcase
        if (start) begin
            proc         = 1'b1;
            addr         = '0;
            init_flag    = init_pend_q | relearn;
            init_pend_d  = 1'b0;
            frame_init_d = init_pend_q | relearn;
        end
        if (proc) begin
            last    = (addr == LAST_ADDR);
            cnt_d   = last ? '0 : addr + ADDR_W'(1);
            state_d = last ? IDLE : RUN;
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            init_pend_q  <= 1'b1;
            frame_init_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            init_pend_q  <= init_pend_d;
            frame_init_q <= frame_init_d;
        end
    end

    // Store read for the accepted pixel; data lands in stage 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q <= '0;
        end else if (proc) begin
            rd_q <= mem[addr];
        end
    end

    // Stage 1: present pixel and stored state to sigma_delta.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid         <= 1'b0;
            s1_addr          <= '0;
            s1_last          <= 1'b0;
            sd_curr_pixel    <= '0;
            sd_wr_background <= 1'b0;
        end else begin
            s1_valid <= proc;
            if (proc) begin
                s1_addr          <= addr;
                s1_last          <= last;
                sd_curr_pixel    <= pix_data;
                sd_wr_background <= init_flag;
            end
        end
    end

    assign sd_enable     = s1_valid;
    assign sd_background = rd_q[2*PIX_W-1:PIX_W];
    assign sd_variance   = rd_q[PIX_W-1:0];

    // Stage 2: track the pixel whose sigma_delta result is now valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_addr  <= '0;
            s2_pixel <= '0;
            s2_last  <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_addr  <= s1_addr;
                s2_pixel <= sd_curr_pixel;
                s2_last  <= s1_last;
            end
        end
    end

    // Write back the updated model; a reset squashes the in-flight write.
    always_ff @(posedge clk) begin
        if (!rst && s2_valid) begin
            mem[s2_addr] <= {sd_background_next, sd_variance_next};
        end
    end

    assign out_valid      = s2_valid;
    assign out_pixel      = s2_valid ? s2_pixel : '0;
    assign out_background = s2_valid ? sd_background_next : '0;
    assign out_variance   = s2_valid ? sd_variance_next : '0;
    assign frame_done     = s2_valid & s2_last;

endmodule

// File: tb/tb_sigma_delta_frame_ctrl.sv
// tb_sigma_delta_frame_ctrl: directed and random frames against a
// frame-level reference model with a simple sigma_delta stand-in.
module tb_sigma_delta_frame_ctrl;

    localparam int NP = 16;
    localparam int AW = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       relearn = 1'b0;
    logic       pix_valid = 1'b0;
    logic       pix_ready;
    logic       pix_sof = 1'b0;
    logic [7:0] pix_data = '0;
    logic       sd_enable;
    logic       sd_wr_background;
    logic [7:0] sd_curr_pixel;
    logic [7:0] sd_background;
    logic [7:0] sd_variance;
    logic [7:0] sd_background_next = '0;
    logic [7:0] sd_variance_next = '0;
    logic       out_valid;
    logic [7:0] out_pixel;
    logic [7:0] out_background;
    logic [7:0] out_variance;
    logic       frame_done;
    logic       sof_err;

    sigma_delta_frame_ctrl #(
        .NUM_PIXELS(NP),
        .ADDR_W    (AW),
        .PIX_W     (8)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .relearn           (relearn),
        .pix_valid         (pix_valid),
        .pix_ready         (pix_ready),
        .pix_sof           (pix_sof),
        .pix_data          (pix_data),
        .sd_enable         (sd_enable),
        .sd_wr_background  (sd_wr_background),
        .sd_curr_pixel     (sd_curr_pixel),
        .sd_background     (sd_background),
        .sd_variance       (sd_variance),
        .sd_background_next(sd_background_next),
        .sd_variance_next  (sd_variance_next),
        .out_valid         (out_valid),
        .out_pixel         (out_pixel),
        .out_background    (out_background),
        .out_variance      (out_variance),
        .frame_done        (frame_done),
        .sof_err           (sof_err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] f_bg(input logic [7:0] p, input logic [7:0] b,
                                        input logic init);
        if (init) return p;
        if (p > b) return b + 8'd1;
        if (p < b) return b - 8'd1;
        return b;
    endfunction

    function automatic logic [7:0] f_var(input logic [7:0] p, input logic [7:0] b,
                                         input logic [7:0] v, input logic init);
        logic [7:0] d;
        d = (p > b) ? p - b : b - p;
        if (init) return 8'd4;
        if (d > v && v != 8'hFF) return v + 8'd1;
        if (d < v && v != 8'h00) return v - 8'd1;
        return v;
    endfunction

    // Stand-in for sigma_delta_update: results one cycle after enable.
    always @(posedge clk) begin
        if (sd_enable) begin
            sd_background_next <= f_bg(sd_curr_pixel, sd_background, sd_wr_background);
            sd_variance_next   <= f_var(sd_curr_pixel, sd_background, sd_variance,
                                        sd_wr_background);
        end
    end

    typedef struct {
        int         stamp;
        logic [7:0] pix;
        int         addr;
        bit         init;
        bit         last;
    } rec_t;

    rec_t       q[$];
    logic [7:0] ref_bg [NP];
    logic [7:0] ref_var[NP];
    bit         ref_valid[NP];

    int n_vec = 0;
    int n_err = 0;
    int cur = 0;
    int n_acc = 0;
    int n_seen = 0;
    int n_fd = 0;

    bit m_in = 0;
    int m_cnt = 0;
    bit m_pend = 1;
    bit m_finit = 0;

    task automatic check(input string tag, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, act, exp, cur);
        end
    endtask

    task automatic cyc(input bit v, input bit s, input bit rl, input bit r,
                       input logic [7:0] d);
        bit         found;
        int         k;
        bit         acc;
        bit         start;
        bit         procd;
        bit         ini;
        bit         lst;
        int         a;
        rec_t       e;
        logic [7:0] eb;
        logic [7:0] ev;
        @(negedge clk);
        pix_valid = v;
        pix_sof   = s;
        relearn   = rl;
        rst       = r;
        pix_data  = d;
        #1;
        found = 0;
        k = 0;
        foreach (q[i]) begin
            if (q[i].stamp == cur - 1) begin
                found = 1;
                k = i;
            end
        end
        check("sd_enable", sd_enable, found);
        if (found) begin
            check("sd_curr_pixel", sd_curr_pixel, q[k].pix);
            check("sd_wr_background", sd_wr_background, q[k].init);
            if (ref_valid[q[k].addr]) begin
                check("sd_background", sd_background, ref_bg[q[k].addr]);
                check("sd_variance", sd_variance, ref_var[q[k].addr]);
            end
        end
        if (q.size() > 0 && q[0].stamp == cur - 2) begin
            e  = q.pop_front();
            eb = f_bg(e.pix, ref_bg[e.addr], e.init);
            ev = f_var(e.pix, ref_bg[e.addr], ref_var[e.addr], e.init);
            check("out_valid", out_valid, 1);
            check("out_pixel", out_pixel, e.pix);
            check("out_background", out_background, eb);
            check("out_variance", out_variance, ev);
            check("frame_done", frame_done, e.last);
            if (!r) begin
                ref_bg[e.addr]    = eb;
                ref_var[e.addr]   = ev;
                ref_valid[e.addr] = 1;
            end
        end else begin
            check("out_valid_idle", out_valid, 0);
            check("frame_done_idle", frame_done, 0);
        end
        if (out_valid === 1'b1) n_seen++;
        if (frame_done === 1'b1) n_fd++;
        check("pix_ready", pix_ready, !r);
        acc = v && !r;
        check("sof_err", sof_err, acc && s && m_in && m_cnt != 0);
        start = acc && s && (!m_in || m_cnt != 0);
        procd = acc && (m_in || s);
        if (start) begin
            ini     = m_pend | rl;
            m_pend  = 0;
            m_finit = ini;
            a       = 0;
        end else begin
            ini = m_finit;
            a   = m_cnt;
            if (rl) m_pend = 1;
        end
        if (procd) begin
            lst   = (a == NP - 1);
            m_cnt = lst ? 0 : a + 1;
            m_in  = !lst;
            q.push_back('{cur, d, a, ini, lst});
            n_acc++;
        end
        if (r) begin
            q.delete();
            m_in   = 0;
            m_cnt  = 0;
            m_pend = 1;
        end
        cur++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 8'h00);
    endtask

    task automatic frame_const(input logic [7:0] p, input int rl_at);
        for (int i = 0; i < NP; i++) cyc(1, i == 0, i == rl_at, 0, p);
    endtask

    task automatic frame_rand();
        for (int i = 0; i < NP; i++) cyc(1, i == 0, 0, 0, 8'($urandom));
    endtask

    initial begin
        int frames_rand;
        int guard;
        int k;
        bit v;
        repeat (3) cyc(0, 0, 0, 1, 8'h00);
        check("rst_sd_curr_pixel", sd_curr_pixel, 0);
        check("rst_sd_background", sd_background, 0);
        check("rst_sd_variance", sd_variance, 0);
        check("rst_sd_wr_background", sd_wr_background, 0);
        check("rst_out_pixel", out_pixel, 0);
        check("rst_out_background", out_background, 0);
        check("rst_out_variance", out_variance, 0);

        for (int i = 0; i < NP; i++) cyc(1, i == 0, 0, 0, 8'(8'h10 + i));
        idle(3);
        frame_const(8'h20, -1);
        idle(3);

        repeat (2) cyc(0, 0, 0, 1, 8'h00);
        repeat (3) cyc(1, 0, 0, 0, 8'hAA);
        frame_rand();
        idle(2);

        for (int i = 0; i < 7; i++) cyc(1, i == 0, 0, 0, 8'(8'h40 + i));
        frame_rand();
        idle(3);

        frame_const(8'h30, 5);
        frame_const(8'h35, -1);
        idle(3);

        for (int i = 0; i < 6; i++) cyc(1, i == 0, 0, 0, 8'(8'h60 + i));
        cyc(1, 0, 0, 1, 8'h66);
        idle(2);
        frame_rand();
        idle(3);

        n_acc  = 0;
        n_seen = 0;
        n_fd   = 0;
        frames_rand = 6;
        for (int f = 0; f < frames_rand; f++) begin
            k = 0;
            guard = 0;
            while (k < NP && guard < 400) begin
                v = 1'($urandom % 2);
                cyc(v, v && k == 0, ($urandom % 16) == 0, 0, 8'($urandom));
                if (v) k++;
                guard++;
            end
            check("rand_frame_budget", k, NP);
        end
        idle(4);
        check("out_count", n_seen, n_acc);
        check("frame_done_count", n_fd, frames_rand);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
